digipot_sched: RTL and testbench

- Scheduler and arbiter in front of the three-channel digipot serial writer.
- Holds one 8-bit shadow value per digipot (pots 0..2). Host writes mark a pot pending.
- Serves pending pots round-robin by driving the writer's mux/ctrl/dato inputs. One transfer runs at a time, with a guaranteed ctrl-high gap between transfers.

---
 rtl/digipot_pkg.sv | 29 ++
 rtl/digipot_sched_rr_arb3.sv | 27 ++
 rtl/digipot_sched.sv | 128 ++++++++++++
 tb/tb_digipot_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/digipot_pkg.sv
// Shared types and constants for the digipot write scheduler.
// State encoding, pot indices and the small helpers used by the top and the arbiter.
package digipot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [1:0] POT0     = 2'd0;
    localparam logic [1:0] POT1     = 2'd1;
    localparam logic [1:0] POT2     = 2'd2;
    localparam logic [1:0] MUX_NONE = 2'b11;

    localparam int NUM_POTS = 3;

    // Successor of a pot index, wrapping 2 -> 0.
    function automatic logic [1:0] next_pot(input logic [1:0] p);
        return (p >= POT2) ? POT0 : p + 2'd1;
    endfunction

    // Down-counter width able to hold the larger of the two phase lengths.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/digipot_sched_rr_arb3.sv
// Combinational 3-way round-robin picker.
// Searches last+1, last+2, last+3 (mod 3) and grants the first requester found.
module rr_arb3
    import digipot_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant_idx,
    output logic       grant_vld
);

    logic [1:0] cand;

    always_comb begin
        grant_idx = POT0;
        grant_vld = 1'b0;
        cand      = last;
        for (int k = 0; k < NUM_POTS; k++) begin
            cand = next_pot(cand);
            if (!grant_vld && req[cand]) begin
                grant_idx = cand;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/digipot_sched.sv
// Scheduler in front of the three-channel digipot serial writer: keeps a shadow per pot
// and serves pending pots round-robin, one SETUP/XFER/GAP transfer at a time.
module digipot_sched
    import digipot_pkg::*;
#(
    parameter int         XFER_CYCLES = 40,
    parameter int         GAP_CYCLES  = 4,
    parameter logic [7:0] DEF_VAL     = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    output logic [1:0] mux,
    output logic       ctrl,
    output logic [7:0] dato,
    output logic       busy,
    output logic [2:0] pending,
    output logic       done,
    output logic [1:0] done_sel,
    output logic       wr_err,
    output logic [1:0] state_dbg
);

    localparam int CW = cnt_width(XFER_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] XFER_LOAD = CW'(XFER_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    last, last_nxt;
    logic [1:0]    mux_nxt;
    logic [7:0]    dato_nxt;
    logic [7:0]    shadow [NUM_POTS];
    logic [2:0]    clr_mask, set_mask, pending_nxt;
    logic          wr_hit;
    logic [1:0]    grant_idx;
    logic          grant_vld;

    rr_arb3 u_arb (
        .req       (pending),
        .last      (last),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign wr_hit   = wr_en && (wr_sel != MUX_NONE);
    assign set_mask = {3{refresh}} | (wr_hit ? (3'b001 << wr_sel) : 3'b000);
    // Setting after clearing lets a same-cycle write keep the pot pending.
    assign pending_nxt = (pending & ~clr_mask) | set_mask;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        mux_nxt   = mux;
        dato_nxt  = dato;
        clr_mask  = 3'b000;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt           = SETUP;
                    mux_nxt             = grant_idx;
                    dato_nxt            = shadow[grant_idx];
                    last_nxt            = grant_idx;
                    clr_mask[grant_idx] = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = XFER;
                cnt_nxt   = XFER_LOAD;
            end
            XFER: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= POT2;
            mux     <= MUX_NONE;
            dato    <= 8'h00;
            pending <= 3'b000;
            wr_err  <= 1'b0;
            for (int i = 0; i < NUM_POTS; i++) begin
                shadow[i] <= DEF_VAL;
            end
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            mux     <= mux_nxt;
            dato    <= dato_nxt;
            pending <= pending_nxt;
            wr_err  <= wr_en && (wr_sel == MUX_NONE);
            for (int i = 0; i < NUM_POTS; i++) begin
                if (wr_hit && (wr_sel == 2'(i))) begin
                    shadow[i] <= wr_data;
                end
            end
        end
    end

    assign ctrl      = (state != XFER);
    assign busy      = (state != IDLE);
    assign done      = (state == GAP) && (cnt == '0);
    assign done_sel  = done ? mux : POT0;
    assign state_dbg = state;

endmodule

// File: tb/tb_digipot_sched.sv
// Directed bench for digipot_sched: timing, round-robin order, collisions and reset abort,
// with transfers checked against an expected queue as ctrl falls.
module tb_digipot_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_sel = 2'd0;
    logic [7:0] wr_data = 8'h00;
    logic       refresh = 1'b0;
    logic [1:0] mux;
    logic       ctrl;
    logic [7:0] dato;
    logic       busy;
    logic [2:0] pending;
    logic       done;
    logic [1:0] done_sel;
    logic       wr_err;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    logic [9:0] exp_q [$];
    logic [1:0] done_q [$];
    logic [9:0] cur_x = '0;
    logic [9:0] exp_x;
    logic       prev_ctrl = 1'b1;

    digipot_sched dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .refresh   (refresh),
        .mux       (mux),
        .ctrl      (ctrl),
        .dato      (dato),
        .busy      (busy),
        .pending   (pending),
        .done      (done),
        .done_sel  (done_sel),
        .wr_err    (wr_err),
        .state_dbg (state_dbg)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic host_write(input logic [1:0] sel, input logic [7:0] data);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = sel; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        @(posedge clk); #1;
        refresh = 1'b1;
        @(posedge clk); #1;
        refresh = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || pending !== 3'b000) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 1000), 32'd1);
        chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_ctrl_low(input string tag);
        int n = 0;
        @(negedge clk);
        while (ctrl !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    // Transfer monitor: pops the expected pot/value at every ctrl fall,
    // checks mux/dato stay put through XFER, and matches done_sel to the transfer.
    always @(negedge clk) begin
        if (rst) begin
            prev_ctrl = 1'b1;
        end else begin
            if (prev_ctrl === 1'b1 && ctrl === 1'b0) begin
                chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_x = exp_q.pop_front();
                    chk("xfer_mux", 32'(mux), 32'(exp_x[9:8]));
                    chk("xfer_dato", 32'(dato), 32'(exp_x[7:0]));
                end
                cur_x = {mux, dato};
                done_q.push_back(mux);
            end else if (prev_ctrl === 1'b0 && ctrl === 1'b0) begin
                chk("xfer_hold", 32'({mux, dato}), 32'(cur_x));
            end
            if (done === 1'b1) begin
                n_done++;
                chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    chk("done_sel", 32'(done_sel), 32'(done_q.pop_front()));
                end
            end
            prev_ctrl = ctrl;
        end
    end

    initial begin
        int done_before;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", 32'(ctrl), 32'd1);
        chk("rst_mux", 32'(mux), 32'd3);
        chk("rst_dato", 32'(dato), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);

        // Refresh after reset: pots 0,1,2 with default value
        exp_q.push_back({2'd0, 8'h80});
        exp_q.push_back({2'd1, 8'h80});
        exp_q.push_back({2'd2, 8'h80});
        pulse_refresh();
        @(negedge clk);
        chk("refresh_pending", 32'(pending), 32'h7);
        wait_idle("refresh_idle");

        // Single write timing, write in cycle t
        exp_q.push_back({2'd1, 8'h5A});
        host_write(2'd1, 8'h5A);
        @(negedge clk);
        chk("sw_pending_t1", 32'(pending), 32'h2);
        chk("sw_busy_t1", 32'(busy), 32'd0);
        step(1);
        chk("sw_mux_t2", 32'(mux), 32'd1);
        chk("sw_dato_t2", 32'(dato), 32'h5A);
        chk("sw_ctrl_t2", 32'(ctrl), 32'd1);
        chk("sw_state_t2", 32'(state_dbg), 32'd1);
        chk("sw_pending_t2", 32'(pending), 32'd0);
        step(1);
        chk("sw_ctrl_t3", 32'(ctrl), 32'd0);
        step(39);
        chk("sw_ctrl_t42", 32'(ctrl), 32'd0);
        step(1);
        chk("sw_ctrl_t43", 32'(ctrl), 32'd1);
        chk("sw_mux_t43", 32'(mux), 32'd1);
        chk("sw_done_t43", 32'(done), 32'd0);
        step(3);
        chk("sw_done_t46", 32'(done), 32'd1);
        chk("sw_done_sel_t46", 32'(done_sel), 32'd1);
        step(1);
        chk("sw_done_t47", 32'(done), 32'd0);
        chk("sw_busy_t47", 32'(busy), 32'd0);
        chk("sw_mux_idle", 32'(mux), 32'd1);

        // Writes 2, 0, 1: pot 2 is alone at the first decision, then 0 and 1 follow
        exp_q.push_back({2'd2, 8'hA2});
        exp_q.push_back({2'd0, 8'hA0});
        exp_q.push_back({2'd1, 8'hA1});
        host_write(2'd2, 8'hA2);
        host_write(2'd0, 8'hA0);
        host_write(2'd1, 8'hA1);
        @(negedge clk);
        chk("rr_pending", 32'(pending), 32'h3);
        wait_idle("rr_idle");

        // Write to pot 1 on the cycle its pending bit is being cleared
        exp_q.push_back({2'd1, 8'h55});
        exp_q.push_back({2'd1, 8'h66});
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = 2'd1; wr_data = 8'h55;
        @(posedge clk); #1;
        wr_data = 8'h66;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("col_state", 32'(state_dbg), 32'd1);
        chk("col_dato", 32'(dato), 32'h55);
        chk("col_pending", 32'(pending), 32'h2);
        wait_idle("col_idle");

        // Rewrite pot 0 during its XFER, plus pot 2: last=0 so 2 goes before 0
        exp_q.push_back({2'd0, 8'h10});
        exp_q.push_back({2'd2, 8'h2C});
        exp_q.push_back({2'd0, 8'h20});
        host_write(2'd0, 8'h10);
        wait_ctrl_low("rw_ctrl_low");
        host_write(2'd0, 8'h20);
        host_write(2'd2, 8'h2C);
        @(negedge clk);
        chk("rw_pending", 32'(pending), 32'h5);
        chk("rw_dato_held", 32'(dato), 32'h10);
        chk("rw_ctrl", 32'(ctrl), 32'd0);
        wait_idle("rw_idle");

        // Illegal select
        host_write(2'd3, 8'hFF);
        @(negedge clk);
        chk("ill_wr_err", 32'(wr_err), 32'd1);
        chk("ill_pending", 32'(pending), 32'd0);
        chk("ill_busy", 32'(busy), 32'd0);
        step(1);
        chk("ill_wr_err_off", 32'(wr_err), 32'd0);
        chk("ill_busy_off", 32'(busy), 32'd0);
        chk("ill_pending_off", 32'(pending), 32'd0);

        // Reset on XFER cycle 10 aborts the transfer
        exp_q.push_back({2'd2, 8'hEE});
        host_write(2'd2, 8'hEE);
        wait_ctrl_low("ra_ctrl_low");
        host_write(2'd0, 8'h77);
        repeat (8) @(posedge clk);
        #1;
        chk("ra_pending_before", 32'(pending), 32'h1);
        chk("ra_ctrl_before", 32'(ctrl), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        done_before = n_done;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ra_ctrl", 32'(ctrl), 32'd1);
        chk("ra_pending", 32'(pending), 32'd0);
        chk("ra_busy", 32'(busy), 32'd0);
        chk("ra_mux", 32'(mux), 32'd3);
        step(60);
        chk("ra_no_done", 32'(n_done - done_before), 32'd0);
        chk("ra_still_idle", 32'(busy), 32'd0);

        // Shadows back at default after reset
        exp_q.push_back({2'd0, 8'h80});
        exp_q.push_back({2'd1, 8'h80});
        exp_q.push_back({2'd2, 8'h80});
        pulse_refresh();
        wait_idle("ra_refresh_idle");
        chk("ra_done_count", 32'(n_done - done_before), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
